// File: rtl/fifo_defines_pkg.sv
// Shared FIFO definitions: sample width, DAC reader defaults and reader FSM encoding.
package fifo_defines_pkg;

    localparam int unsigned DATA_WIDTH      = 16;
    localparam int unsigned DAC_CLK_DIV_DEF = 4;
    localparam int unsigned DAC_GAP_DEF     = 2;

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_SHIFT, RD_GAP} reader_state_t;

endpackage

// File: rtl/dac_serializer.sv
// MSB-first serializer for the DAC link: a load captures a word and starts a frame of
// DATA_WIDTH bits, each a CLK_DIV-cycle low phase followed by a CLK_DIV-cycle high phase.
module dac_serializer #(
    parameter int unsigned DATA_WIDTH = fifo_defines_pkg::DATA_WIDTH,
    parameter int unsigned CLK_DIV    = fifo_defines_pkg::DAC_CLK_DIV_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  sclk,
    output logic                  sdo,
    output logic                  last_bit
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);

    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_next;
    logic                  active;
    logic                  phase_end;

    assign shreg_next = shreg << 1;
    assign phase_end  = active && (div_cnt == DIV_W'(CLK_DIV - 1));
    // Final cycle of the last high phase; the frame ends on the following edge.
    assign last_bit   = phase_end && sclk && (bit_cnt == BIT_W'(DATA_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            active  <= 1'b0;
            sclk    <= 1'b0;
            sdo     <= 1'b0;
        end else if (load) begin
            shreg   <= data;
            sdo     <= data[DATA_WIDTH-1];
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            active  <= 1'b1;
        end else if (active) begin
            if (phase_end) begin
                div_cnt <= '0;
                if (!sclk) begin
                    sclk <= 1'b1;
                end else begin
                    // sdo only moves here, at the start of a low phase
                    sclk    <= 1'b0;
                    shreg   <= shreg_next;
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    if (last_bit) begin
                        active <= 1'b0;
                        sdo    <= 1'b0;
                    end else begin
                        sdo <= shreg_next[DATA_WIDTH-1];
                    end
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/fifo_dac_reader.sv
// FIFO read-side DAC driver: pops one sample per frame and streams it over cs_n/sclk/sdo.
// Optional FIFO_DAC_READER_SAMPLE_CNT_EN adds a 16-bit completed-frame counter output.
module fifo_dac_reader #(
    parameter int unsigned DATA_WIDTH = fifo_defines_pkg::DATA_WIDTH,
    parameter int unsigned CLK_DIV    = fifo_defines_pkg::DAC_CLK_DIV_DEF,
    parameter int unsigned GAP_CYCLES = fifo_defines_pkg::DAC_GAP_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic                         empty_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    output logic                         rd_en_o,
    output logic                         cs_n_o,
    output logic                         sclk_o,
    output logic                         sdo_o,
    output logic                         busy_o,
    output logic                         done_o
`ifdef FIFO_DAC_READER_SAMPLE_CNT_EN
    ,
    output logic [15:0]                  sample_cnt_o
`endif
);

    import fifo_defines_pkg::*;

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    reader_state_t    state;
    logic [GAP_W-1:0] gap_cnt;
    logic             load;
    logic             last_bit;

    // Pop is suppressed while reset is held so a reset never costs a sample.
    assign rd_en_o = (state == RD_IDLE) && !rst && en_i && !empty_i;
    assign load    = (state == RD_WAIT);

    dac_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CLK_DIV    (CLK_DIV)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data     (data_i),
        .sclk     (sclk_o),
        .sdo      (sdo_o),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RD_IDLE;
            gap_cnt <= '0;
            cs_n_o  <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                RD_IDLE: begin
                    if (rd_en_o) begin
                        state  <= RD_WAIT;
                        busy_o <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    state  <= RD_SHIFT;
                    cs_n_o <= 1'b0;
                end
                RD_SHIFT: begin
                    if (last_bit) begin
                        state   <= RD_GAP;
                        cs_n_o  <= 1'b1;
                        done_o  <= 1'b1;
                        gap_cnt <= '0;
                    end
                end
                RD_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state   <= RD_IDLE;
                        busy_o  <= 1'b0;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

`ifdef FIFO_DAC_READER_SAMPLE_CNT_EN
    // Counts frames as they complete; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt_o <= '0;
        end else if ((state == RD_SHIFT) && last_bit) begin
            sample_cnt_o <= sample_cnt_o + 16'd1;
        end
    end
`endif

endmodule
